// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Segment patterns {g,f,e,d,c,b,a}, active-high, indexed by hex digit.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Width needed for a counter that runs up to max(a,b)-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern.
  always_comb begin
    seg = HEX_SEG_TABLE[hex];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Scans NUM_DIGITS digits, each driven for SCAN_DIV cycles with BLANK_CYCLES
// of dead time between digits. Define SEG7_BRIGHTNESS_EN to add a 3-bit
// brightness input that trims the active portion of each DRIVE period.
//
// state    | meaning
// ST_BLANK | dead time, outputs zero, cnt counts BLANK_CYCLES
// ST_DRIVE | digit idx lit, cnt counts SCAN_DIV
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
`ifdef SEG7_BRIGHTNESS_EN
  input  logic [2:0]                    brightness,
`endif
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         digit_sel
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = cnt_width(SCAN_DIV, BLANK_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_nxt;
  logic [CW-1:0]         cnt_q, cnt_nxt;
  logic [IW-1:0]         idx_q, idx_nxt;
  logic [3:0]            val_q [NUM_DIGITS];
  logic                  wr_fire;
  logic [3:0]            drive_val;
  logic [6:0]            dec_seg;
  logic                  bright_on;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  // The digit currently lit cannot be rewritten until its DRIVE ends.
  assign wr_ready = !(ena && (state_q == ST_DRIVE) && (wr_addr == idx_q));
  assign wr_fire  = wr_valid && wr_ready;

  // State, counter and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
    end
  end

  // Next-state logic; everything holds while ena is low.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    if (ena) begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_nxt = ST_DRIVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
            idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end
        default: begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Digit value registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        val_q[i] <= '0;
      end
    end else if (wr_fire && (32'(wr_addr) < NUM_DIGITS)) begin
      val_q[wr_addr] <= wr_data;
    end
  end

  // Forward a same-edge write so the first DRIVE cycle already shows it.
  assign drive_val = (wr_fire && (wr_addr == idx_nxt)) ? wr_data : val_q[idx_nxt];

  seg7_hex_decode u_hex_decode (
    .hex (drive_val),
    .seg (dec_seg)
  );

`ifdef SEG7_BRIGHTNESS_EN
  assign bright_on = (32'(cnt_nxt) * 32'd8) <
                     ((32'(brightness) + 32'd1) * 32'(SCAN_DIV));
`else
  assign bright_on = 1'b1;
`endif

  // Output values for the upcoming cycle, so registered outputs align with state.
  always_comb begin
    seg_nxt = '0;
    sel_nxt = '0;
    if (ena && (state_nxt == ST_DRIVE) && bright_on) begin
      seg_nxt = dec_seg;
      sel_nxt = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nxt;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg       <= '0;
      digit_sel <= '0;
    end else begin
      seg       <= seg_nxt;
      digit_sel <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, BLANK_CYCLES=2).
module tb_seg7_scan_ctrl;

`ifdef SEG7_BRIGHTNESS_EN
  localparam int SD = 8;
`else
  localparam int SD = 4;
`endif
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [6:0] seg;
  logic [3:0] digit_sel;
`ifdef SEG7_BRIGHTNESS_EN
  logic [2:0] brightness;
`endif

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0] addr;
    logic [3:0] data;
    logic [3:0] sel;
    logic [6:0] seg;
  } vec_t;

  vec_t vt [4];

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
`ifdef SEG7_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned outs();
    return {21'd0, digit_sel, seg};
  endfunction

  // One full blank + drive period, starting on the first blank cycle.
  task automatic check_period(input logic [3:0] esel, input logic [6:0] eseg, input string tag);
    for (int k = 0; k < BC; k++) begin
      chk({tag, "_blank"}, outs(), 0);
      step();
    end
    for (int k = 0; k < SD; k++) begin
      chk({tag, "_drive"}, outs(), {21'd0, esel, eseg});
      step();
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall;
    int active;

    vt[0] = '{2'd0, 4'h1, 4'b0001, 7'h06};
    vt[1] = '{2'd1, 4'h2, 4'b0010, 7'h5B};
    vt[2] = '{2'd2, 4'h3, 4'b0100, 7'h4F};
    vt[3] = '{2'd3, 4'h4, 4'b1000, 7'h66};

    rst_n    = 1'b0;
    ena      = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 2'd0;
    wr_data  = 4'h8;
`ifdef SEG7_BRIGHTNESS_EN
    brightness = 3'd7;
`endif

    // Reset: outputs zero, ready high, write during reset discarded.
    step();
    chk("rst_outs", outs(), 0);
    chk("rst_ready", {31'd0, wr_ready}, 1);
    step();
    @(negedge clk);
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    #1;
    check_period(4'b0001, 7'h3F, "reset_d0");

    // Fresh reset, load digits with ena low, then scan through the table.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = vt[i].addr;
      wr_data  = vt[i].data;
      #1;
      chk("load_ready", {31'd0, wr_ready}, 1);
      step();
      chk("load_outs", outs(), 0);
    end
    wr_valid = 1'b0;
    ena      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_period(vt[i].sel, vt[i].seg, "scan");
    end
    check_period(vt[0].sel, vt[0].seg, "scan_wrap");

    // Stall: write to the lit digit waits for the following BLANK.
    repeat (BC) step();
    wr_valid = 1'b1;
    wr_addr  = 2'd1;
    wr_data  = 4'h9;
    #1;
    stall = 0;
    while (!wr_ready && stall < 4 * SD) begin
      chk("stall_seg_held", outs(), {21'd0, 4'b0010, 7'h5B});
      step();
      stall++;
    end
    chk("stall_len", stall, SD);
    chk("stall_release", {31'd0, wr_ready}, 1);
    step();
    wr_valid = 1'b0;
    repeat (BC - 1) step();
    // Write to a different digit mid-drive is accepted at once.
    wr_valid = 1'b1;
    wr_addr  = 2'd3;
    wr_data  = 4'hE;
    #1;
    chk("other_ready", {31'd0, wr_ready}, 1);
    step();
    wr_valid = 1'b0;
    chk("other_seg_held", outs(), {21'd0, 4'b0100, 7'h4F});
    repeat (SD - 1) step();
    check_period(4'b1000, 7'h79, "other_landed");
    check_period(4'b0001, 7'h06, "d0_again");
    check_period(4'b0010, 7'h6F, "stall_landed");

    // Enable: freeze mid-drive for 10 cycles, then finish the DRIVE.
    repeat (BC) step();
    chk("ena_pre", outs(), {21'd0, 4'b0100, 7'h4F});
    step();
    step();
    ena     = 1'b0;
    wr_addr = 2'd2;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ena_off_outs", outs(), 0);
      chk("ena_off_ready", {31'd0, wr_ready}, 1);
    end
    ena = 1'b1;
    for (int k = 3; k < SD; k++) begin
      step();
      chk("ena_resume", outs(), {21'd0, 4'b0100, 7'h4F});
    end
    step();
    check_period(4'b1000, 7'h79, "ena_next");

    // Async reset mid-drive, no clock edge.
    repeat (BC) step();
    chk("ares_pre", outs(), {21'd0, 4'b0001, 7'h06});
    #2;
    rst_n = 1'b0;
    #1;
    chk("ares_outs", outs(), 0);
    chk("ares_ready", {31'd0, wr_ready}, 1);
    wr_valid = 1'b1;
    wr_addr  = 2'd1;
    wr_data  = 4'h3;
    step();
    step();
    @(negedge clk);
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    #1;
    check_period(4'b0001, 7'h3F, "ares_d0");
    check_period(4'b0010, 7'h3F, "ares_d1");

`ifdef SEG7_BRIGHTNESS_EN
    // Brightness 1: first 2 of 8 drive cycles lit; brightness 7: all 8.
    brightness = 3'd1;
    repeat (BC) step();
    active = 0;
    for (int k = 0; k < SD; k++) begin
      chk("bright1", outs(), (k < 2) ? {21'd0, 4'b0100, 7'h3F} : 32'd0);
      if (digit_sel != 4'b0000) active++;
      step();
    end
    chk("bright1_count", active, 2);
    brightness = 3'd7;
    check_period(4'b1000, 7'h3F, "bright7");
`else
    active = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit is driven (>=2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 2, dead-time clock cycles between digits (>=1).
REQ-004 SHALL have port clk  input  1  single clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ena  input  1  design enable; low holds the scan frozen and the display blanked.
REQ-007 SHALL have port wr_valid  input  1  digit write request.
REQ-008 SHALL have port wr_ready  output  1  digit write accepted this cycle when high with wr_valid.
REQ-009 SHALL have port wr_addr  input  clog2(NUM_DIGITS)  digit index to write.
REQ-010 SHALL have port wr_data  input  4  hex value for that digit.
REQ-011 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-012 SHALL have port digit_sel  output  NUM_DIGITS  one-hot digit enable, active-high.

Function
REQ-013 SHALL hold one 4-bit value register per digit; a write occurs on a rising clk edge with wr_valid and wr_ready both high.
REQ-014 SHALL implement FSM states BLANK and DRIVE, plus a current digit index idx and a cycle counter cnt.
REQ-015 SHALL stay in BLANK for BLANK_CYCLES cycles, then enter DRIVE with cnt cleared.
REQ-016 SHALL stay in DRIVE for SCAN_DIV cycles, then enter BLANK and advance idx, wrapping from NUM_DIGITS-1 to 0.
REQ-017 SHALL register outputs: during DRIVE, digit_sel is one-hot(idx) and seg is hex-decode(value[idx]); during BLANK both are all zero.
REQ-018 SHALL decode hex as 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-019 SHALL drive wr_ready low only when state is DRIVE and wr_addr equals idx; the write stalls until the next BLANK, so seg never changes mid-drive.
REQ-020 SHALL, while ena is low, hold state, idx and cnt, force seg and digit_sel to zero, and keep wr_ready high.
REQ-021 SHALL resume scanning from the held state and count once ena returns high.
REQ-022 SHALL, when the cycle that leaves DRIVE also carries a stalled write to idx, accept that write on the first BLANK cycle.

Reset
REQ-023 SHALL, with rst_n low, immediately clear state to BLANK, idx and cnt to 0, all digit values to 0, and seg and digit_sel to 0.
REQ-024 SHALL drive wr_ready high during reset; writes presented during reset are discarded.
REQ-025 SHALL, after rst_n deasserts, start with BLANK_CYCLES of blank and then drive digit 0 showing 3F.

Configuration
REQ-026 SHALL honour macro SEG7_BRIGHTNESS_EN; when defined, it adds input port brightness[2:0]. During DRIVE, digit_sel and seg are active only while cnt*8 < (brightness+1)*SCAN_DIV, and zero for the rest of DRIVE. Timing is otherwise unchanged.
REQ-027 SHALL, without SEG7_BRIGHTNESS_EN, omit the brightness port and drive outputs for the full DRIVE period.

Structure
REQ-028 SHALL place the FSM state enum and the 16-entry hex-to-segment constant table in shared package seg7_pkg.
REQ-029 SHALL implement the hex decoder as sub-module seg7_hex_decode (4-bit in, 7-bit out, combinational).

Verification
REQ-030 SHALL cover reset: SCAN_DIV=4, BLANK_CYCLES=2, release rst_n -> 2 cycles of zeros, then digit_sel=0001 and seg=3F for 4 cycles.
REQ-031 SHALL cover scan: write digits 1,2,3,4 -> sequence 0001/06, 0010/5B, 0100/4F, 1000/66, separated by 2 blank cycles, then wrap to 0001.
REQ-032 SHALL cover stall: write addr=idx during DRIVE -> wr_ready=0 until the first BLANK cycle, then accept; an addr!=idx write is accepted the same cycle.
REQ-033 SHALL cover enable: drop ena mid-DRIVE for 10 cycles -> outputs zero, wr_ready=1; on resume, the remaining DRIVE cycles complete.
REQ-034 SHALL cover async reset: assert rst_n mid-DRIVE without a clk edge -> outputs zero immediately, digit values cleared.
REQ-035 SHALL cover brightness (macro defined, SCAN_DIV=8): brightness=1 -> digit active for 2 of 8 DRIVE cycles; brightness=7 -> active for all 8.
